// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_pkg : RV32M funct3 encodings, datapath width and sequencer state type
// Revision: 1.0
// ----------------------------------------------------------------------------
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_step : one combinational restoring-division iteration on {rem,quot}
// Revision: 1.0
// ----------------------------------------------------------------------------
module div_step #(
  parameter int W = md_pkg::XLEN
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quot,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quot_next
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem < divisor on entry, so a W+1 bit difference carries the borrow in its MSB.
  always_comb begin
    shifted = {rem, quot[W-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[W]) begin
      rem_next  = shifted[W-1:0];
      quot_next = {quot[W-2:0], 1'b0};
    end else begin
      rem_next  = trial[W-1:0];
      quot_next = {quot[W-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq : EX-stage RV32M sequencer (registered multiply, 32-step divide)
// Revision: 1.0
// ----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int XLEN         = md_pkg::XLEN,
  parameter bit DIV_SHORTCUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            MDDoneE,
  output logic [XLEN-1:0] MDResultE
);

  import md_pkg::*;

  localparam int CW = $clog2(XLEN);

  md_state_t       state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_signed_div;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            in_overflow;

  logic            a_sx;
  logic            b_sx;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;

  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quot;

  div_step #(.W(XLEN)) u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  // Operand preparation for a new divide, taken straight from the EX inputs.
  always_comb begin
    in_signed_div = (Funct3E == F3_DIV) || (Funct3E == F3_REM);
    a_mag         = (in_signed_div && SrcAE[XLEN-1]) ? (-SrcAE) : SrcAE;
    b_mag         = (in_signed_div && SrcBE[XLEN-1]) ? (-SrcBE) : SrcBE;
    in_overflow   = in_signed_div &&
                    (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
  end

  // Extending both operands to 2*XLEN makes the low 2*XLEN product bits exact.
  always_comb begin
    a_sx  = ((funct3_q == F3_MULH) || (funct3_q == F3_MULHSU)) && a_q[XLEN-1];
    b_sx  = (funct3_q == F3_MULH) && b_q[XLEN-1];
    a_ext = {{XLEN{a_sx}}, a_q};
    b_ext = {{XLEN{b_sx}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_comb begin
    q_neg    = ~funct3_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg    = ~funct3_q[0] & a_q[XLEN-1];
    quot_fix = q_neg ? (-quot_q) : quot_q;
    rem_fix  = r_neg ? (-rem_q) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    result_d  = result_q;
    cnt_d     = cnt_q;

    if (FlushE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (StartE) begin
            funct3_d  = Funct3E;
            a_d       = SrcAE;
            b_d       = SrcBE;
            divisor_d = b_mag;
            rem_d     = '0;
            quot_d    = a_mag;
            cnt_d     = CW'(XLEN - 1);
            if (!Funct3E[2]) begin
              state_d = ST_MUL;
            end else if (DIV_SHORTCUT && (SrcBE == '0)) begin
              result_d = Funct3E[1] ? SrcAE : '1;
              state_d  = ST_DONE;
            end else if (DIV_SHORTCUT && in_overflow) begin
              result_d = Funct3E[1] ? '0 : SrcAE;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_d = (funct3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = funct3_q[1] ? rem_fix : quot_fix;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          // StartE is still high for the retiring op; never re-accept here.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  assign StallMD   = ~FlushE & (((state_q == ST_IDLE) & StartE) |
                                (state_q == ST_MUL) | (state_q == ST_DIV) |
                                (state_q == ST_FIX));
  assign MDDoneE   = (state_q == ST_DONE);
  assign MDResultE = result_q;

endmodule
`default_nettype wire
